// File: rtl/video_timing_gen.sv
// Raster timing generator: display counter plus a lookahead request counter,
// with registered sync, draw-area, strobes and frame count derived from the next positions.

module video_timing_gen_cnt #(
    parameter int H_TOTAL = 2,
    parameter int V_TOTAL = 2,
    parameter int XW      = 1,
    parameter int YW      = 1,
    parameter int X_INIT  = 0,
    parameter int Y_INIT  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [XW-1:0] nx,
    output logic [YW-1:0] ny
);
    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_RST  = XW'(X_INIT);
    localparam logic [YW-1:0] Y_RST  = YW'(Y_INIT);

    always_comb begin
        nx = x + 1'b1;
        ny = y;
        if (x == X_LAST) begin
            nx = '0;
            ny = (y == Y_LAST) ? '0 : y + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= X_RST;
            y <= Y_RST;
        end else if (en) begin
            x <= nx;
            y <= ny;
        end
    end
endmodule

module video_timing_gen #(
    parameter int H_PIXELS      = 800,
    parameter int H_FRONT_PORCH = 48,
    parameter int H_SYNC        = 32,
    parameter int H_BACK_PORCH  = 80,
    parameter int V_PIXELS      = 600,
    parameter int V_FRONT_PORCH = 3,
    parameter int V_SYNC        = 4,
    parameter int V_BACK_PORCH  = 11,
    parameter int HSYNC_POL     = 1,
    parameter int VSYNC_POL     = 0,
    parameter int LOOKAHEAD     = 0,
    localparam int H_TOTAL = H_PIXELS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH,
    localparam int V_TOTAL = V_PIXELS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          draw_area,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count,
    output logic          req_valid,
    output logic [XW-1:0] req_x,
    output logic [YW-1:0] req_y
);
    localparam int HS_START = H_PIXELS + H_FRONT_PORCH;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_PIXELS + V_FRONT_PORCH;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam logic HS_OFF = (HSYNC_POL == 0);
    localparam logic VS_OFF = (VSYNC_POL == 0);

    // Request counter starts LOOKAHEAD raster positions past the reset display position.
    localparam int RAST  = H_TOTAL * V_TOTAL;
    localparam int R_IDX = (V_PIXELS * H_TOTAL + LOOKAHEAD) % RAST;
    localparam int RX0   = R_IDX % H_TOTAL;
    localparam int RY0   = R_IDX / H_TOTAL;
    localparam logic RV0 = (RX0 < H_PIXELS) && (RY0 < V_PIXELS);

    logic [XW-1:0] d_nx, r_nx;
    logic [YW-1:0] d_ny, r_ny;
    logic          hs_act, vs_act, wrap_n;

    video_timing_gen_cnt #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .XW(XW), .YW(YW),
        .X_INIT(0), .Y_INIT(V_PIXELS)
    ) u_disp (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y), .nx(d_nx), .ny(d_ny)
    );

    video_timing_gen_cnt #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .XW(XW), .YW(YW),
        .X_INIT(RX0), .Y_INIT(RY0)
    ) u_req (
        .clk(clk), .rst_n(rst_n), .en(en), .x(req_x), .y(req_y), .nx(r_nx), .ny(r_ny)
    );

    function automatic logic in_area(input logic [XW-1:0] cx, input logic [YW-1:0] cy);
        return (32'(cx) < H_PIXELS) && (32'(cy) < V_PIXELS);
    endfunction

    assign hs_act = (32'(d_nx) >= HS_START) && (32'(d_nx) < HS_END);
    assign vs_act = (32'(d_ny) >= VS_START) && (32'(d_ny) < VS_END);
    assign wrap_n = (d_nx == '0) && (d_ny == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= HS_OFF;
            vsync       <= VS_OFF;
            draw_area   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            req_valid   <= RV0;
        end else if (en) begin
            hsync       <= hs_act ^ HS_OFF;
            vsync       <= vs_act ^ VS_OFF;
            draw_area   <= in_area(d_nx, d_ny);
            line_start  <= (d_nx == '0);
            frame_start <= wrap_n;
            req_valid   <= in_area(r_nx, r_ny);
            if (wrap_n) frame_count <= frame_count + 16'd1;
        end
    end
endmodule
